// File: rtl/m_ext_scheduler_if.sv
// m_ext_scheduler_if
// Purpose: bundles the signals of the RV32M scheduler into one interface.
//   It covers the execute-stage request, the multiplier and divider control
//   and result signals, and the writeback response handshake.
//   slave  : the scheduler's view. It receives requests and unit results,
//            and drives the unit controls and the response.
//   master : the environment's view. This is the pipeline plus the units.
// Signal summary:
//   req_valid/req_op/req_a/req_b/req_rd : M-op presented by execute
//   flush                               : kill the in-flight op
//   stall                               : hold the pipeline front end
//   mul_start/mul_opcode                : multiplier control
//   div_start/div_opcode                : divider control
//   operand1/operand2                   : latched operands to both units
//   mul_done/mul_result                 : multiplier completion
//   div_done/div_result                 : divider completion
//   resp_valid/resp_ready/resp_rd/resp_data : writeback handshake
//   timeout_err                         : sticky unit-timeout flag
interface m_ext_scheduler_if;
    logic        req_valid;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall;
    logic        mul_start;
    logic [1:0]  mul_opcode;
    logic        div_start;
    logic [1:0]  div_opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        mul_done;
    logic [31:0] mul_result;
    logic        div_done;
    logic [31:0] div_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        timeout_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, flush,
        input  mul_done, mul_result, div_done, div_result, resp_ready,
        output stall, mul_start, mul_opcode, div_start, div_opcode,
        output operand1, operand2, resp_valid, resp_rd, resp_data, timeout_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, flush,
        output mul_done, mul_result, div_done, div_result, resp_ready,
        input  stall, mul_start, mul_opcode, div_start, div_opcode,
        input  operand1, operand2, resp_valid, resp_rd, resp_data, timeout_err
    );
endinterface

// File: rtl/m_ext_scheduler.sv
// m_ext_scheduler
// Purpose: sequences the shared iterative multiplier and the 32-bit divider
//   for RV32M ops in the execute stage. It accepts one M-op at a time. It
//   issues a one-cycle start pulse to the correct unit and holds the operands
//   and opcode until that unit reports done. It registers the result and
//   delivers it to writeback through a valid/ready handshake.
//   Divide-by-zero and signed overflow are resolved without using the
//   divider. Flushes are handled, and a wait-state timeout aborts a hung unit.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset; it also resets the units
//   bus  : m_ext_scheduler_if.slave (request, unit control/result, response)
// Parameters:
//   TIMEOUT_CYCLES : wait cycles allowed before an op is aborted
module m_ext_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    m_ext_scheduler_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MSTART = 3'd1,
        S_MWAIT  = 3'd2,
        S_DSTART = 3'd3,
        S_DWAIT  = 3'd4,
        S_RESP   = 3'd5,
        S_DRAIN  = 3'd6
    } state_t;

    // The M codes run 01011..10010. Each group of four maps to the unit
    // opcodes 00..11 through its low two bits plus one.
    function automatic logic [1:0] f_unit_code(input logic [4:0] op);
        f_unit_code = op[1:0] + 2'd1;
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_mul_start;
    logic               r_div_start;
    logic [1:0]         r_mul_opcode;
    logic [1:0]         r_div_opcode;
    logic [31:0]        r_operand1;
    logic [31:0]        r_operand2;
    logic               r_resp_valid;
    logic [4:0]         r_resp_rd;
    logic [31:0]        r_resp_data;
    logic               r_timeout_err;

    logic               w_req_is_mul;
    logic               w_req_is_div;
    logic               w_m_req;
    logic [1:0]         w_req_code;
    logic               w_div_by_zero;
    logic               w_overflow;
    logic               w_fast;
    logic [31:0]        w_fast_data;
    logic               w_accept;
    logic               w_capture_mul;
    logic               w_capture_div;
    logic               w_timeout;
    logic               w_stall;
    logic               w_busy_done;
    logic               w_wait_expire;
    logic               w_drain_expire;

    assign w_req_is_mul  = (bus.req_op >= 5'd11) && (bus.req_op <= 5'd14);
    assign w_req_is_div  = (bus.req_op >= 5'd15) && (bus.req_op <= 5'd18);
    assign w_m_req       = bus.req_valid && (w_req_is_mul || w_req_is_div);
    assign w_req_code    = f_unit_code(bus.req_op);

    // Code bit 0 marks the unsigned forms and code bit 1 marks the remainder
    // forms. Signed overflow only exists for DIV and REM.
    assign w_div_by_zero = (bus.req_b == 32'd0);
    assign w_overflow    = !w_req_code[0] && (bus.req_a == 32'h8000_0000) &&
                           (bus.req_b == 32'hFFFF_FFFF);
    assign w_fast        = w_req_is_div && (w_div_by_zero || w_overflow);

    // After a timeout the counter already sits at TIMEOUT_CYCLES, so the
    // drain ends at once. After a flush the drain keeps the wait budget.
    assign w_wait_expire  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_drain_expire = (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_busy_done    = r_is_div ? bus.div_done : bus.mul_done;

    // Short-circuit result for divide-by-zero and signed overflow
    always_comb begin
        w_fast_data = 32'd0;
        if (w_div_by_zero) begin
            w_fast_data = w_req_code[1] ? bus.req_a : 32'hFFFF_FFFF;
        end else if (w_overflow) begin
            w_fast_data = w_req_code[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            w_fast_data = 32'd0;
        end
    end

    // Next-state and control decode for the scheduler FSM
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_capture_mul = 1'b0;
        w_capture_div = 1'b0;
        w_timeout     = 1'b0;
        w_stall       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_stall = w_m_req;
                if (w_m_req && !bus.flush) begin
                    w_accept = 1'b1;
                    if (w_fast) begin
                        w_next_state = S_RESP;
                    end else if (w_req_is_div) begin
                        w_next_state = S_DSTART;
                    end else begin
                        w_next_state = S_MSTART;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MSTART: begin
                w_next_state = bus.flush ? S_DRAIN : S_MWAIT;
            end
            S_DSTART: begin
                w_next_state = bus.flush ? S_DRAIN : S_DWAIT;
            end
            S_MWAIT: begin
                if (bus.flush) begin
                    // A done that arrives with the flush leaves nothing to drain
                    w_next_state = bus.mul_done ? S_IDLE : S_DRAIN;
                end else if (bus.mul_done) begin
                    w_capture_mul = 1'b1;
                    w_next_state  = S_RESP;
                end else if (w_wait_expire) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_DRAIN;
                end else begin
                    w_next_state = S_MWAIT;
                end
            end
            S_DWAIT: begin
                if (bus.flush) begin
                    w_next_state = bus.div_done ? S_IDLE : S_DRAIN;
                end else if (bus.div_done) begin
                    w_capture_div = 1'b1;
                    w_next_state  = S_RESP;
                end else if (w_wait_expire) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_DRAIN;
                end else begin
                    w_next_state = S_DWAIT;
                end
            end
            S_RESP: begin
                w_stall = !bus.resp_ready;
                if (bus.flush || bus.resp_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            S_DRAIN: begin
                w_stall = w_m_req;
                if (w_busy_done || w_drain_expire) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            default: begin
                w_stall      = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Wait/drain counter; cleared while idle and on each unit start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((w_next_state == S_IDLE) || (r_state == S_MSTART) ||
                     (r_state == S_DSTART)) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == S_MWAIT) || (r_state == S_DWAIT) ||
                     (r_state == S_DRAIN)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Registered unit controls, latched operands and response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_div      <= 1'b0;
            r_mul_start   <= 1'b0;
            r_div_start   <= 1'b0;
            r_mul_opcode  <= 2'b00;
            r_div_opcode  <= 2'b00;
            r_operand1    <= 32'd0;
            r_operand2    <= 32'd0;
            r_resp_valid  <= 1'b0;
            r_resp_rd     <= 5'd0;
            r_resp_data   <= 32'd0;
            r_timeout_err <= 1'b0;
        end else begin
            // Start pulses last exactly one cycle because START states do
            r_mul_start  <= (w_next_state == S_MSTART);
            r_div_start  <= (w_next_state == S_DSTART);
            r_resp_valid <= (w_next_state == S_RESP);

            if (w_accept) begin
                r_is_div     <= w_req_is_div;
                r_operand1   <= bus.req_a;
                r_operand2   <= bus.req_b;
                r_resp_rd    <= bus.req_rd;
                r_mul_opcode <= w_req_is_mul ? w_req_code : 2'b00;
                r_div_opcode <= w_req_is_div ? w_req_code : 2'b00;
            end else if (w_next_state == S_IDLE) begin
                r_operand1   <= 32'd0;
                r_operand2   <= 32'd0;
                r_mul_opcode <= 2'b00;
                r_div_opcode <= 2'b00;
            end else begin
                r_operand1   <= r_operand1;
                r_operand2   <= r_operand2;
            end

            if (w_accept && w_fast) begin
                r_resp_data <= w_fast_data;
            end else if (w_capture_mul) begin
                r_resp_data <= bus.mul_result;
            end else if (w_capture_div) begin
                r_resp_data <= bus.div_result;
            end else if (w_timeout) begin
                r_resp_data <= 32'd0;
            end else begin
                r_resp_data <= r_resp_data;
            end

            // Sticky until reset
            r_timeout_err <= r_timeout_err | w_timeout;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.mul_start   = r_mul_start;
    assign bus.mul_opcode  = r_mul_opcode;
    assign bus.div_start   = r_div_start;
    assign bus.div_opcode  = r_div_opcode;
    assign bus.operand1    = r_operand1;
    assign bus.operand2    = r_operand2;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_rd     = r_resp_rd;
    assign bus.resp_data   = r_resp_data;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_m_ext_scheduler.sv
// tb_m_ext_scheduler: directed self-checking bench for m_ext_scheduler.
// The bench plays the role of both the pipeline and the two arithmetic units.
// Inputs change 1 ns after each rising edge, and outputs are sampled there.
module tb_m_ext_scheduler;

    localparam logic [4:0] OP_MUL   = 5'b01011;
    localparam logic [4:0] OP_MULHU = 5'b01110;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_REM   = 5'b10001;
    localparam logic [4:0] OP_REMU  = 5'b10010;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    m_ext_scheduler_if bus ();

    m_ext_scheduler #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
    endtask

    task automatic handshake();
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    // Fast-path vectors: op, a, b, expected result
    logic [4:0]  fp_op  [5] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU};
    logic [31:0] fp_a   [5] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'd55};
    logic [31:0] fp_b   [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] fp_exp [5] = '{32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 5'd0; bus.req_a = 32'd0; bus.req_b = 32'd0;
        bus.req_rd = 5'd0; bus.flush = 1'b0; bus.mul_done = 1'b0; bus.mul_result = 32'd0;
        bus.div_done = 1'b0; bus.div_result = 32'd0; bus.resp_ready = 1'b0;
        step();
        step();
        check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("rst_mul_start", {31'd0, bus.mul_start}, 32'd0);
        check_eq("rst_operand1", bus.operand1, 32'd0);
        check_eq("rst_timeout", {31'd0, bus.timeout_err}, 32'd0);
        rst = 1'b1;
        step();

        // ---- MUL 7*6, unit done 5 cycles after the start pulse ----
        present(OP_MUL, 32'd7, 32'd6, 5'd3);
        #1;
        check_eq("mul_stall_req", {31'd0, bus.stall}, 32'd1);
        step();
        bus.req_valid = 1'b0;
        check_eq("mul_start", {31'd0, bus.mul_start}, 32'd1);
        check_eq("mul_opcode", {30'd0, bus.mul_opcode}, 32'd0);
        check_eq("mul_op1", bus.operand1, 32'd7);
        check_eq("mul_op2", bus.operand2, 32'd6);
        check_eq("mul_no_div_start", {31'd0, bus.div_start}, 32'd0);
        step();
        check_eq("mul_start_once", {31'd0, bus.mul_start}, 32'd0);
        bus.div_done = 1'b1;
        bus.div_result = 32'hDEAD_BEEF;
        step();
        bus.div_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("mul_wait_valid", {31'd0, bus.resp_valid}, 32'd0);
            check_eq("mul_wait_stall", {31'd0, bus.stall}, 32'd1);
            check_eq("mul_hold_op1", bus.operand1, 32'd7);
            step();
        end
        bus.mul_done = 1'b1;
        bus.mul_result = 32'd42;
        step();
        bus.mul_done = 1'b0;
        check_eq("mul_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        check_eq("mul_resp_data", bus.resp_data, 32'd42);
        check_eq("mul_resp_rd", {27'd0, bus.resp_rd}, 32'd3);
        check_eq("mul_resp_stall", {31'd0, bus.stall}, 32'd1);
        bus.resp_ready = 1'b1;
        #1;
        check_eq("mul_ready_stall", {31'd0, bus.stall}, 32'd0);
        step();
        bus.resp_ready = 1'b0;
        check_eq("mul_idle_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("mul_idle_op1", bus.operand1, 32'd0);

        // ---- divide-by-zero and signed overflow short-circuits ----
        for (int i = 0; i < 5; i++) begin
            present(fp_op[i], fp_a[i], fp_b[i], 5'd5);
            step();
            bus.req_valid = 1'b0;
            check_eq("fast_valid", {31'd0, bus.resp_valid}, 32'd1);
            check_eq("fast_no_start", {31'd0, bus.div_start}, 32'd0);
            check_eq("fast_data", bus.resp_data, fp_exp[i]);
            handshake();
            check_eq("fast_done", {31'd0, bus.resp_valid}, 32'd0);
        end

        // ---- DIVU 100/7 with writeback held off for 4 cycles ----
        present(OP_DIVU, 32'd100, 32'd7, 5'd9);
        step();
        bus.req_valid = 1'b0;
        check_eq("divu_start", {31'd0, bus.div_start}, 32'd1);
        check_eq("divu_opcode", {30'd0, bus.div_opcode}, 32'd1);
        check_eq("divu_op2", bus.operand2, 32'd7);
        step();
        bus.div_done = 1'b1;
        bus.div_result = 32'd14;
        step();
        bus.div_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("divu_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            check_eq("divu_hold_data", bus.resp_data, 32'd14);
            check_eq("divu_hold_rd", {27'd0, bus.resp_rd}, 32'd9);
            step();
        end
        bus.resp_ready = 1'b1;
        #1;
        check_eq("divu_ready_stall", {31'd0, bus.stall}, 32'd0);
        step();
        bus.resp_ready = 1'b0;
        check_eq("divu_idle_valid", {31'd0, bus.resp_valid}, 32'd0);
        present(OP_REMU, 32'd100, 32'd7, 5'd10);
        step();
        bus.req_valid = 1'b0;
        check_eq("remu_start", {31'd0, bus.div_start}, 32'd1);
        check_eq("remu_opcode", {30'd0, bus.div_opcode}, 32'd3);
        step();
        bus.div_done = 1'b1;
        bus.div_result = 32'd2;
        step();
        bus.div_done = 1'b0;
        check_eq("remu_data", bus.resp_data, 32'd2);
        check_eq("remu_rd", {27'd0, bus.resp_rd}, 32'd10);
        handshake();

        // ---- flush two cycles into DWAIT, MUL waits for the late div_done ----
        present(OP_DIV, 32'd50, 32'd5, 5'd4);
        step();
        bus.req_valid = 1'b0;
        check_eq("fl_div_start", {31'd0, bus.div_start}, 32'd1);
        step();
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check_eq("fl_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("fl_drain_stall_idle", {31'd0, bus.stall}, 32'd0);
        present(OP_MUL, 32'd3, 32'd4, 5'd6);
        #1;
        check_eq("fl_drain_stall_req", {31'd0, bus.stall}, 32'd1);
        step();
        check_eq("fl_mul_blocked", {31'd0, bus.mul_start}, 32'd0);
        bus.div_done = 1'b1;
        bus.div_result = 32'd10;
        step();
        bus.div_done = 1'b0;
        check_eq("fl_late_done_dropped", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("fl_idle_no_start", {31'd0, bus.mul_start}, 32'd0);
        step();
        bus.req_valid = 1'b0;
        check_eq("fl_mul_start", {31'd0, bus.mul_start}, 32'd1);
        check_eq("fl_mul_op1", bus.operand1, 32'd3);
        step();
        bus.mul_done = 1'b1;
        bus.mul_result = 32'd12;
        step();
        bus.mul_done = 1'b0;
        check_eq("fl_mul_data", bus.resp_data, 32'd12);
        check_eq("fl_mul_rd", {27'd0, bus.resp_rd}, 32'd6);
        handshake();

        // ---- divider never answers: timeout after 8 wait cycles ----
        present(OP_DIVU, 32'd9, 32'd3, 5'd7);
        step();
        bus.req_valid = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            check_eq("to_not_yet", {31'd0, bus.timeout_err}, 32'd0);
            step();
        end
        check_eq("to_err_set", {31'd0, bus.timeout_err}, 32'd1);
        check_eq("to_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("to_data_zero", bus.resp_data, 32'd0);
        check_eq("to_drain_stall", {31'd0, bus.stall}, 32'd0);
        step();
        present(OP_MUL, 32'd2, 32'd2, 5'd8);
        step();
        bus.req_valid = 1'b0;
        check_eq("to_idle_accepts", {31'd0, bus.mul_start}, 32'd1);
        step();
        bus.mul_done = 1'b1;
        bus.mul_result = 32'd4;
        step();
        bus.mul_done = 1'b0;
        check_eq("to_after_data", bus.resp_data, 32'd4);
        handshake();
        check_eq("to_err_sticky", {31'd0, bus.timeout_err}, 32'd1);

        // ---- asynchronous reset in the middle of MWAIT ----
        present(OP_MUL, 32'd5, 32'd5, 5'd2);
        step();
        bus.req_valid = 1'b0;
        step();
        check_eq("rs_op1_held", bus.operand1, 32'd5);
        #2 rst = 1'b0;
        #1;
        check_eq("rs_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("rs_op1", bus.operand1, 32'd0);
        check_eq("rs_timeout", {31'd0, bus.timeout_err}, 32'd0);
        check_eq("rs_resp_data", bus.resp_data, 32'd0);
        rst = 1'b1;
        step();
        check_eq("rs_idle_stall", {31'd0, bus.stall}, 32'd0);
        present(OP_MULHU, 32'd1, 32'd1, 5'd1);
        step();
        bus.req_valid = 1'b0;
        check_eq("rs_mulhu_start", {31'd0, bus.mul_start}, 32'd1);
        check_eq("rs_mulhu_opcode", {30'd0, bus.mul_opcode}, 32'd3);
        step();
        bus.mul_done = 1'b1;
        bus.mul_result = 32'd0;
        step();
        bus.mul_done = 1'b0;
        check_eq("rs_mulhu_valid", {31'd0, bus.resp_valid}, 32'd1);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/m_ext_scheduler.md
Name: m_ext_scheduler

Overview:
- Sequences the shared iterative multiplier and 32-bit divider for RV32M instructions in the execute stage.
- Accepts one M-op at a time and issues a single-cycle start pulse to the correct unit, holding operands/opcode stable until done.
- Stalls the pipeline, registers the result and delivers it to writeback with a valid/ready handshake.
- Short-circuits divide-by-zero and signed overflow per the RISC-V spec, and handles flush and timeout.

Parameters:
TIMEOUT_CYCLES, 64, wait-state cycles before abort; counter width is clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  execute stage presents instruction
req_op  in  5  alu_op: MUL=01011 MULH=01100 MULHSU=01101 MULHU=01110 DIV=01111 DIVU=10000 REM=10001 REMU=10010
req_a  in  32  SrcA
req_b  in  32  SrcB
req_rd  in  5  destination register
flush  in  1  kill in-flight op
stall  out  1  hold pipeline front end
mul_start  out  1  one-cycle start pulse to multiplier
mul_opcode  out  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
div_start  out  1  one-cycle start pulse to divider
div_opcode  out  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
operand1  out  32  latched SrcA to units
operand2  out  32  latched SrcB to units
mul_done  in  1  multiplier finished, result valid this cycle
mul_result  in  32  multiplier result
div_done  in  1  divider finished
div_result  in  32  divider result
resp_valid  out  1  result available
resp_ready  in  1  writeback accepts
resp_rd  out  5  rd of result
resp_data  out  32  result
timeout_err  out  1  sticky, set on timeout

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including opcodes=00, operands=0 and timeout_err=0; counter=0. Reset mid-operation abandons the op. The units are reset by the same rst.
- States: IDLE, MSTART, MWAIT, DSTART, DWAIT, RESP, DRAIN.
- m_req = req_valid & req_op in the 8 M codes. Other ops are ignored.
- IDLE, m_req, no flush: latch op, a, b and rd at the edge.
  - DIV/REM with b==0: RESP. DIV/DIVU result 0xFFFFFFFF; REM/REMU result a.
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF: RESP. DIV result 0x80000000; REM result 0.
  - Other MUL ops go to MSTART; other DIV ops go to DSTART.
- MSTART/DSTART: mul_start/div_start=1 for exactly this cycle. Go to MWAIT/DWAIT and clear the counter.
- MWAIT/DWAIT: hold operands and opcode. On the matching done, register the result into resp_data and go to RESP. The done of the other unit is ignored.
- Timeout: counter increments each wait cycle. At TIMEOUT_CYCLES without done: timeout_err<=1, resp_data<=0, go to DRAIN.
- RESP: resp_valid=1 and resp_rd/resp_data are stable. When resp_ready=1, go to IDLE. resp_valid is held indefinitely while resp_ready=0.
- stall = (state!=IDLE) | (state==IDLE & m_req). It goes low in the RESP cycle where resp_ready=1.
- Flush in MSTART/MWAIT/DSTART/DWAIT: go to DRAIN (the start pulse, if in a START state, still fires); no resp. Flush in RESP: IDLE, no resp. Flush in IDLE: the request is not accepted.
- DRAIN: wait for done of the busy unit, or counter expiry. Then go to IDLE. While in DRAIN, stall = m_req and no new request is accepted.
- Start outputs are registered; start is never asserted while the unit is busy. Operands are zeroed on return to IDLE.
- Latency: accept edge T, start in T+1, done at cycle D, resp_valid in D+1. Fast path gives resp_valid at T+1.

Test Plan:
- MUL a=7, b=6 with the unit returning done after 5 cycles -> single-cycle mul_start with opcode 00, operands held; resp_valid 1 cycle after done, resp_data=42, stall high until handshake.
- DIV a=100, b=0 -> no div_start; resp_valid next cycle, data 0xFFFFFFFF. REMU a=100, b=0 -> data 100. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- DIVU 100/7 with resp_ready held low for 4 cycles -> resp_valid and data 14 stable for all 4 cycles; state to IDLE on the ready cycle; a back-to-back REMU is accepted the next cycle with result 2.
- Flush 2 cycles into DWAIT, then a new MUL is presented -> no resp, stall follows m_req in DRAIN; MUL starts only after div_done; the late div_done is not delivered.
- Divider never asserts done, TIMEOUT_CYCLES=8 -> timeout_err=1 after 8 wait cycles, DRAIN then IDLE, no resp; the error stays set until rst.
- Reset asserted during MWAIT -> all outputs 0 immediately (async); IDLE after release.
